// File: rtl/cpu_pkg.sv
// Shared constants and types for the memory/writeback stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;

   // Load size/sign encodings carried in funct3. 3'b111 is not listed and
   // is handled as a full doubleword load by the extender's default arm.
   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LD  = 3'b011,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101,
      F3_LWU = 3'b110
   } load_f3_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WB       = 2'd2
   } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Extracts the addressed byte/half/word from a loaded doubleword and sign- or zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   i_funct3   - load size/sign (LB..LWU, 3'b111 behaves as LD)
//   i_addr_low - load address bits [2:0]; bits below the access size are ignored
//   i_dword    - aligned doubleword containing the load address
//   o_data     - extended load value
module load_extend #(
   parameter int XLEN = cpu_pkg::XLEN
) (
   input  logic [2:0]      i_funct3,
   input  logic [2:0]      i_addr_low,
   input  logic [XLEN-1:0] i_dword,
   output logic [XLEN-1:0] o_data
);
   import cpu_pkg::*;

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_word;

   // Lane selection drops the address bits below the access size, so a
   // misaligned address simply reads the naturally aligned lane.
   assign w_byte = i_dword[{i_addr_low, 3'b000} +: 8];
   assign w_half = i_dword[{i_addr_low[2:1], 4'b0000} +: 16];
   assign w_word = i_dword[{i_addr_low[2], 5'b00000} +: 32];

   always_comb begin
      o_data = i_dword;
      case (i_funct3)
         F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
         F3_LW:   o_data = {{(XLEN-32){w_word[31]}}, w_word};
         F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
         F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
         F3_LWU:  o_data = {{(XLEN-32){1'b0}}, w_word};
         default: o_data = i_dword;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: retires one instruction per handshake and drives the register-file write port.
// Latency: non-load writes one cycle after accept; loads write one cycle after the memory response.
// Backpressure: in_ready is low only while waiting for a load response; non-loads sustain 1/cycle.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid / in_ready           - upstream handshake; fields captured on the accepting edge
//   in_rd, in_reg_write           - destination register and write enable
//   in_mem_read, in_funct3,
//   in_addr_low                   - load flag, load size/sign, address bits [2:0]
//   in_alu_result                 - result for non-load instructions
//   mem_rsp_valid, mem_rsp_data   - data-memory response (aligned doubleword)
//   write_register, write_data,
//   reg_write                     - register-file write port; writes to x0 are suppressed
//   perf_retired, perf_stall      - optional counters, present only when WB_PERF_EN is defined
module mem_wb_stage #(
   parameter int XLEN       = cpu_pkg::XLEN,
   parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_reg_write,
   input  logic                  in_mem_read,
   input  logic [2:0]            in_funct3,
   input  logic [2:0]            in_addr_low,
   input  logic [XLEN-1:0]       in_alu_result,
   input  logic                  mem_rsp_valid,
   input  logic [XLEN-1:0]       mem_rsp_data,
   output logic [REG_ADDR_W-1:0] write_register,
   output logic [XLEN-1:0]       write_data,
   output logic                  reg_write
`ifdef WB_PERF_EN
   ,
   output logic [31:0]           perf_retired,
   output logic [31:0]           perf_stall
`endif
);
   import cpu_pkg::*;

   wb_state_t             r_state;
   wb_state_t             w_next_state;

   // Fields of the instruction in flight (needed while a load waits).
   logic [REG_ADDR_W-1:0] r_rd;
   logic                  r_reg_write;
   logic [2:0]            r_funct3;
   logic [2:0]            r_addr_low;

   // Register-file write port, held between writes.
   logic [REG_ADDR_W-1:0] r_wr_reg;
   logic [XLEN-1:0]       r_wr_data;
   logic                  r_wr_en;

   logic                  w_accept;
   logic                  w_rsp_take;
   logic [XLEN-1:0]       w_load_val;

   assign in_ready   = (r_state != WAIT_MEM);
   assign w_accept   = in_valid && in_ready;
   // A response is only meaningful once the load is parked in WAIT_MEM.
   assign w_rsp_take = (r_state == WAIT_MEM) && mem_rsp_valid;

   load_extend #(
      .XLEN (XLEN)
   ) u_load_extend (
      .i_funct3   (r_funct3),
      .i_addr_low (r_addr_low),
      .i_dword    (mem_rsp_data),
      .o_data     (w_load_val)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE, WB: begin
            if (w_accept) begin
               w_next_state = in_mem_read ? WAIT_MEM : WB;
            end else begin
               w_next_state = IDLE;
            end
         end
         WAIT_MEM: begin
            if (mem_rsp_valid) begin
               w_next_state = WB;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rd        <= '0;
         r_reg_write <= 1'b0;
         r_funct3    <= '0;
         r_addr_low  <= '0;
         r_wr_reg    <= '0;
         r_wr_data   <= '0;
         r_wr_en     <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_wr_en <= 1'b0;
         if (w_accept) begin
            r_rd        <= in_rd;
            r_reg_write <= in_reg_write;
            r_funct3    <= in_funct3;
            r_addr_low  <= in_addr_low;
            if (!in_mem_read) begin
               r_wr_reg  <= in_rd;
               r_wr_data <= in_alu_result;
               r_wr_en   <= in_reg_write && (in_rd != '0);
            end
         end else if (w_rsp_take) begin
            r_wr_reg  <= r_rd;
            r_wr_data <= w_load_val;
            r_wr_en   <= r_reg_write && (r_rd != '0);
         end
      end
   end

   assign write_register = r_wr_reg;
   assign write_data     = r_wr_data;
   assign reg_write      = r_wr_en;

`ifdef WB_PERF_EN
   logic [31:0] r_perf_retired;
   logic [31:0] r_perf_stall;

   // Both counters wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_retired <= '0;
         r_perf_stall   <= '0;
      end else begin
         if (r_wr_en) begin
            r_perf_retired <= r_perf_retired + 32'd1;
         end
         if ((r_state == WAIT_MEM) && !mem_rsp_valid) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_retired = r_perf_retired;
   assign perf_stall   = r_perf_stall;
`else
   // Counters are compiled out; the stage behaves identically without them.
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed sequences, a load-extraction
// vector table, and randomized traffic checked against a transaction-level model.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic        in_mem_read;
   logic [2:0]  in_funct3;
   logic [2:0]  in_addr_low;
   logic [63:0] in_alu_result;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;
   logic [4:0]  write_register;
   logic [63:0] write_data;
   logic        reg_write;
`ifdef WB_PERF_EN
   logic [31:0] perf_retired;
   logic [31:0] perf_stall;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mem_wb_stage dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_rd          (in_rd),
      .in_reg_write   (in_reg_write),
      .in_mem_read    (in_mem_read),
      .in_funct3      (in_funct3),
      .in_addr_low    (in_addr_low),
      .in_alu_result  (in_alu_result),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .write_register (write_register),
      .write_data     (write_data),
      .reg_write      (reg_write)
`ifdef WB_PERF_EN
      ,
      .perf_retired   (perf_retired),
      .perf_stall     (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // Reference extraction from the load rules: access size from funct3,
   // naturally aligned offset, shift, mask, then optional sign fill.
   function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] a,
                                            input logic [63:0] d);
      int          size;
      int          off;
      logic [63:0] mask;
      logic [63:0] v;
      size = 1 << int'(f3[1:0]);
      off  = int'(a) - (int'(a) % size);
      v    = d >> (8 * off);
      if (size == 8) return v;
      mask = (64'd1 << (8 * size)) - 64'd1;
      v    = v & mask;
      if (!f3[2] && v[8*size-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic idle_inputs();
      in_valid      = 1'b0;
      in_rd         = '0;
      in_reg_write  = 1'b0;
      in_mem_read   = 1'b0;
      in_funct3     = '0;
      in_addr_low   = '0;
      in_alu_result = '0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic we, input logic [63:0] alu);
      in_valid      = 1'b1;
      in_mem_read   = 1'b0;
      in_rd         = rd;
      in_reg_write  = we;
      in_alu_result = alu;
      in_funct3     = 3'($urandom);
      in_addr_low   = 3'($urandom);
   endtask

   task automatic drive_load(input logic [4:0] rd, input logic we, input logic [2:0] f3,
                             input logic [2:0] a);
      in_valid      = 1'b1;
      in_mem_read   = 1'b1;
      in_rd         = rd;
      in_reg_write  = we;
      in_funct3     = f3;
      in_addr_low   = a;
      in_alu_result = {$urandom, $urandom};
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [2:0]  addr;
      logic [63:0] data;
      logic [63:0] exp;
   } ld_vec_t;

   ld_vec_t     vecs[12];
   logic [4:0]  exp_reg;
   logic [63:0] exp_data;

   initial begin
      vecs[0]  = '{3'b000, 3'd3, 64'h0000_0000_0080_0000, 64'h0000_0000_0000_0000};
      vecs[1]  = '{3'b000, 3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
      vecs[2]  = '{3'b110, 3'd4, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321};
      vecs[3]  = '{3'b010, 3'd4, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
      vecs[4]  = '{3'b001, 3'd6, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001};
      vecs[5]  = '{3'b101, 3'd7, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001};
      vecs[6]  = '{3'b100, 3'd5, 64'h0000_F000_0000_0000, 64'h0000_0000_0000_00F0};
      vecs[7]  = '{3'b011, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
      vecs[8]  = '{3'b111, 3'd0, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210};
      vecs[9]  = '{3'b010, 3'd0, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};
      vecs[10] = '{3'b001, 3'd1, 64'h0000_0000_0000_ABCD, 64'hFFFF_FFFF_FFFF_ABCD};
      vecs[11] = '{3'b000, 3'd0, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_007F};

      idle_inputs();
      rst = 1'b1;

      // Reset then idle
      tick();
      tick();
      chk("reset reg_write", 64'(reg_write), 64'd0);
      chk("reset write_data", write_data, 64'd0);
      chk("reset write_register", 64'(write_register), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      tick();
      chk("idle reg_write", 64'(reg_write), 64'd0);

      // Back-to-back ALU ops
      drive_alu(5'd5, 1'b1, 64'h1234);
      chk("b2b in_ready 0", 64'(in_ready), 64'd1);
      tick();
      chk("b2b0 reg_write", 64'(reg_write), 64'd1);
      chk("b2b0 write_register", 64'(write_register), 64'd5);
      chk("b2b0 write_data", write_data, 64'h1234);
      drive_alu(5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("b2b in_ready 1", 64'(in_ready), 64'd1);
      tick();
      chk("b2b1 reg_write", 64'(reg_write), 64'd1);
      chk("b2b1 write_register", 64'(write_register), 64'd6);
      chk("b2b1 write_data", write_data, 64'hFFFF_FFFF_FFFF_FFFF);
      idle_inputs();
      tick();
      chk("b2b drop reg_write", 64'(reg_write), 64'd0);
      chk("b2b hold write_register", 64'(write_register), 64'd6);
      chk("b2b hold write_data", write_data, 64'hFFFF_FFFF_FFFF_FFFF);

      // x0 suppression
      drive_alu(5'd0, 1'b1, 64'h55);
      tick();
      chk("x0 reg_write", 64'(reg_write), 64'd0);
      chk("x0 write_data", write_data, 64'h55);
      idle_inputs();
      tick();

      // Load extraction table: response two cycles after accept
      for (int i = 0; i < 12; i++) begin
         drive_load(5'(10 + i), 1'b1, vecs[i].f3, vecs[i].addr);
         mem_rsp_valid = 1'b1;  // must be ignored on the accepting edge
         mem_rsp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
         tick();
         in_valid      = 1'b1;  // not accepted while waiting
         in_mem_read   = 1'b0;
         mem_rsp_valid = 1'b0;
         chk($sformatf("ld%0d wait1 in_ready", i), 64'(in_ready), 64'd0);
         chk($sformatf("ld%0d wait1 reg_write", i), 64'(reg_write), 64'd0);
         tick();
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = vecs[i].data;
         chk($sformatf("ld%0d wait2 in_ready", i), 64'(in_ready), 64'd0);
         tick();
         idle_inputs();
         chk($sformatf("ld%0d reg_write", i), 64'(reg_write), 64'd1);
         chk($sformatf("ld%0d write_register", i), 64'(write_register), 64'(10 + i));
         chk($sformatf("ld%0d write_data", i), write_data, vecs[i].exp);
         tick();
         chk($sformatf("ld%0d drop reg_write", i), 64'(reg_write), 64'd0);
      end

      // Reset mid-load: rst on wait cycle 2, response on wait cycle 3
      drive_load(5'd9, 1'b1, 3'b011, 3'd0);
      tick();
      idle_inputs();
      tick();
      rst = 1'b1;
      tick();
      rst           = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h1111_2222_3333_4444;
      chk("rstld in_ready", 64'(in_ready), 64'd1);
      tick();
      mem_rsp_valid = 1'b0;
      chk("rstld reg_write", 64'(reg_write), 64'd0);
      chk("rstld write_data", write_data, 64'd0);
      tick();
      chk("rstld later reg_write", 64'(reg_write), 64'd0);
      chk("rstld later in_ready", 64'(in_ready), 64'd1);

      // Randomized traffic against the transaction model
      exp_reg  = write_register;
      exp_data = write_data;
      chk("rand start write_register", 64'(exp_reg), 64'd0);
      for (int t = 0; t < 300; t++) begin
         int          kind;
         logic [4:0]  rd;
         logic        we;
         logic [2:0]  f3;
         logic [2:0]  a;
         logic [63:0] v;
         int          waits;
         kind = $urandom_range(0, 3);
         rd   = 5'($urandom);
         if ($urandom_range(0, 7) == 0) rd = 5'd0;
         we   = ($urandom_range(0, 3) != 0);
         if (kind == 0) begin
            idle_inputs();
            mem_rsp_valid = 1'($urandom);
            mem_rsp_data  = {$urandom, $urandom};
            tick();
            chk("rand idle reg_write", 64'(reg_write), 64'd0);
            chk("rand idle write_register", 64'(write_register), 64'(exp_reg));
            chk("rand idle write_data", write_data, exp_data);
         end else if (kind < 3) begin
            v = {$urandom, $urandom};
            drive_alu(rd, we, v);
            mem_rsp_valid = 1'($urandom);
            chk("rand alu in_ready", 64'(in_ready), 64'd1);
            tick();
            exp_reg  = rd;
            exp_data = v;
            chk("rand alu reg_write", 64'(reg_write), 64'(we && rd != 5'd0));
            chk("rand alu write_register", 64'(write_register), 64'(exp_reg));
            chk("rand alu write_data", write_data, exp_data);
         end else begin
            f3    = 3'($urandom);
            a     = 3'($urandom);
            waits = $urandom_range(0, 3);
            drive_load(rd, we, f3, a);
            mem_rsp_valid = 1'($urandom);
            mem_rsp_data  = {$urandom, $urandom};
            chk("rand ld in_ready", 64'(in_ready), 64'd1);
            tick();
            for (int w = 0; w < waits; w++) begin
               in_valid      = 1'($urandom);
               in_mem_read   = 1'($urandom);
               mem_rsp_valid = 1'b0;
               chk("rand ld wait in_ready", 64'(in_ready), 64'd0);
               chk("rand ld wait reg_write", 64'(reg_write), 64'd0);
               chk("rand ld wait write_data", write_data, exp_data);
               tick();
            end
            v             = {$urandom, $urandom};
            in_valid      = 1'($urandom);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = v;
            chk("rand ld rsp in_ready", 64'(in_ready), 64'd0);
            tick();
            exp_reg  = rd;
            exp_data = ref_load(f3, a, v);
            chk("rand ld reg_write", 64'(reg_write), 64'(we && rd != 5'd0));
            chk("rand ld write_register", 64'(write_register), 64'(exp_reg));
            chk("rand ld write_data", write_data, exp_data);
         end
      end
      idle_inputs();
      tick();
      chk("final reg_write", 64'(reg_write), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
